kmeans_accum_k3_d5: RTL and testbench

KMEANS_ACCUM_K3_D5 -- requirements
Module: kmeans_accum_k3_d5

---
 rtl/kmeans_accum_k3_d5.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_kmeans_accum_k3_d5.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_accum_k3_d5.sv
// -----------------------------------------------------------------------------
// kmeans_accum_k3_d5
//
// Purpose: accumulates classified samples (5 dimensions, 3 centroids) during a
// pass.  At the end of the pass it divides every per-centroid sum by that
// centroid's sample count, using a serial restoring divider, and produces the
// new centroid positions.
//
// Pass flow: ACCUM (samples accepted) -> DIV (15 elements, SW+2 cycles each)
//            -> DONE (one cycle, out_valid pulse, accumulators cleared).
//
// Parameters
//   input_data_width : unsigned sample / centroid component width
//   count_width      : per-centroid sample counter width
//   (sum width SW = input_data_width + count_width)
//
// Ports
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid, in_last              : sample strobe, last-sample-of-pass flag
//   input_data0..input_data4       : sample dimensions d0..d4
//   selected_centroid              : nearest centroid 0..2 (3 = no update)
//   in_ready                       : high while accumulating
//   centroid0_d0..centroid2_d4     : registered centroid components
//   cluster_count0..2              : per-centroid pass counts (optional)
//   out_valid                      : one-cycle pulse when all centroids updated
//
// Optional feature: define KMEANS_ACCUM_COUNT_OUT_EN to add the
// cluster_count0..cluster_count2 outputs, captured on the DIV-entry edge.
// -----------------------------------------------------------------------------
module kmeans_accum_k3_d5 #(
  parameter int input_data_width = 16,
  parameter int count_width      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic [input_data_width-1:0] input_data0,
  input  logic [input_data_width-1:0] input_data1,
  input  logic [input_data_width-1:0] input_data2,
  input  logic [input_data_width-1:0] input_data3,
  input  logic [input_data_width-1:0] input_data4,
  input  logic [1:0]                  selected_centroid,
  output logic                        in_ready,
  output logic [input_data_width-1:0] centroid0_d0,
  output logic [input_data_width-1:0] centroid0_d1,
  output logic [input_data_width-1:0] centroid0_d2,
  output logic [input_data_width-1:0] centroid0_d3,
  output logic [input_data_width-1:0] centroid0_d4,
  output logic [input_data_width-1:0] centroid1_d0,
  output logic [input_data_width-1:0] centroid1_d1,
  output logic [input_data_width-1:0] centroid1_d2,
  output logic [input_data_width-1:0] centroid1_d3,
  output logic [input_data_width-1:0] centroid1_d4,
  output logic [input_data_width-1:0] centroid2_d0,
  output logic [input_data_width-1:0] centroid2_d1,
  output logic [input_data_width-1:0] centroid2_d2,
  output logic [input_data_width-1:0] centroid2_d3,
  output logic [input_data_width-1:0] centroid2_d4,
`ifdef KMEANS_ACCUM_COUNT_OUT_EN
  output logic [count_width-1:0]      cluster_count0,
  output logic [count_width-1:0]      cluster_count1,
  output logic [count_width-1:0]      cluster_count2,
`endif
  output logic                        out_valid
);

  localparam int IW = input_data_width;
  localparam int CW = count_width;
  localparam int SW = input_data_width + count_width;
  // Phase counter covers load (0), SW iterations (1..SW) and writeback (SW+1).
  localparam int PW = $clog2(SW + 2);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DIV   = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sum_q [3][5];
  logic [SW-1:0]   sum_d [3][5];
  logic [CW-1:0]   cnt_q [3];
  logic [CW-1:0]   cnt_d [3];
  logic [IW-1:0]   cent_q [3][5];
  logic [IW-1:0]   cent_d [3][5];

  // Serial divider state: dvd holds the dividend, shifting left while the
  // quotient bits enter at the LSB; after SW steps it holds the quotient.
  logic [SW-1:0]   dvd_q, dvd_d;
  logic [CW-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [1:0]      k_q, k_d;
  logic [2:0]      d_q, d_d;
  logic            out_valid_q, out_valid_d;

`ifdef KMEANS_ACCUM_COUNT_OUT_EN
  logic [CW-1:0]   ccount_q [3];
  logic [CW-1:0]   ccount_d [3];
`endif

  logic [IW-1:0]   sample [5];
  logic            accept;
  logic [CW:0]     rem_sh;

  assign sample[0] = input_data0;
  assign sample[1] = input_data1;
  assign sample[2] = input_data2;
  assign sample[3] = input_data3;
  assign sample[4] = input_data4;

  assign in_ready = (state_q == ACCUM);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    cent_d      = cent_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    phase_d     = phase_q;
    k_d         = k_q;
    d_d         = d_q;
    out_valid_d = 1'b0;
    rem_sh      = {rem_q, dvd_q[SW-1]};
`ifdef KMEANS_ACCUM_COUNT_OUT_EN
    ccount_d    = ccount_q;
`endif

    case (state_q)
      ACCUM: begin
        if (accept) begin
          // selected_centroid == 3 matches no k, so nothing accumulates.
          for (int k = 0; k < 3; k++) begin
            if (selected_centroid == 2'(k)) begin
              for (int d = 0; d < 5; d++) begin
                sum_d[k][d] = sum_q[k][d] + SW'(sample[d]);
              end
              cnt_d[k] = cnt_q[k] + CW'(1);
            end
          end
          if (in_last) begin
            state_d = DIV;
            phase_d = '0;
            k_d     = 2'd0;
            d_d     = 3'd0;
`ifdef KMEANS_ACCUM_COUNT_OUT_EN
            // cnt_d already includes a sample accepted together with in_last.
            ccount_d = cnt_d;
`endif
          end
        end
      end

      DIV: begin
        if (phase_q == '0) begin
          // Load: select the current element's sum and its centroid's count.
          for (int k = 0; k < 3; k++) begin
            if (k_q == 2'(k)) begin
              dvs_d = cnt_q[k];
              for (int d = 0; d < 5; d++) begin
                if (d_q == 3'(d)) begin
                  dvd_d = sum_q[k][d];
                end
              end
            end
          end
          rem_d   = '0;
          phase_d = phase_q + PW'(1);
        end else if (phase_q != PW'(SW + 1)) begin
          // One restoring step.  When the trial subtraction succeeds the
          // true remainder is below dvs, so the low CW bits are exact.
          if (rem_sh >= {1'b0, dvs_q}) begin
            rem_d = rem_sh[CW-1:0] - dvs_q;
            dvd_d = {dvd_q[SW-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[CW-1:0];
            dvd_d = {dvd_q[SW-2:0], 1'b0};
          end
          phase_d = phase_q + PW'(1);
        end else begin
          // Writeback; an empty centroid keeps its previous position.
          if (dvs_q != '0) begin
            for (int k = 0; k < 3; k++) begin
              for (int d = 0; d < 5; d++) begin
                if (k_q == 2'(k) && d_q == 3'(d)) begin
                  cent_d[k][d] = dvd_q[IW-1:0];
                end
              end
            end
          end
          phase_d = '0;
          if (d_q == 3'd4) begin
            d_d = 3'd0;
            k_d = k_q + 2'd1;
          end else begin
            d_d = d_q + 3'd1;
          end
          if (k_q == 2'd2 && d_q == 3'd4) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end
        end
      end

      DONE: begin
        for (int k = 0; k < 3; k++) begin
          cnt_d[k] = '0;
          for (int d = 0; d < 5; d++) begin
            sum_d[k][d] = '0;
          end
        end
        state_d = ACCUM;
      end

      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      phase_q     <= '0;
      k_q         <= 2'd0;
      d_q         <= 3'd0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= '0;
`ifdef KMEANS_ACCUM_COUNT_OUT_EN
        ccount_q[k] <= '0;
`endif
        for (int d = 0; d < 5; d++) begin
          sum_q[k][d]  <= '0;
          cent_q[k][d] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      phase_q     <= phase_d;
      k_q         <= k_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= cnt_d[k];
`ifdef KMEANS_ACCUM_COUNT_OUT_EN
        ccount_q[k] <= ccount_d[k];
`endif
        for (int d = 0; d < 5; d++) begin
          sum_q[k][d]  <= sum_d[k][d];
          cent_q[k][d] <= cent_d[k][d];
        end
      end
    end
  end

  assign out_valid    = out_valid_q;

  assign centroid0_d0 = cent_q[0][0];
  assign centroid0_d1 = cent_q[0][1];
  assign centroid0_d2 = cent_q[0][2];
  assign centroid0_d3 = cent_q[0][3];
  assign centroid0_d4 = cent_q[0][4];
  assign centroid1_d0 = cent_q[1][0];
  assign centroid1_d1 = cent_q[1][1];
  assign centroid1_d2 = cent_q[1][2];
  assign centroid1_d3 = cent_q[1][3];
  assign centroid1_d4 = cent_q[1][4];
  assign centroid2_d0 = cent_q[2][0];
  assign centroid2_d1 = cent_q[2][1];
  assign centroid2_d2 = cent_q[2][2];
  assign centroid2_d3 = cent_q[2][3];
  assign centroid2_d4 = cent_q[2][4];

`ifdef KMEANS_ACCUM_COUNT_OUT_EN
  assign cluster_count0 = ccount_q[0];
  assign cluster_count1 = ccount_q[1];
  assign cluster_count2 = ccount_q[2];
`endif

endmodule

// File: tb/tb_kmeans_accum_k3_d5.sv
// -----------------------------------------------------------------------------
// tb_kmeans_accum_k3_d5
//
// Directed bench for kmeans_accum_k3_d5.  A reference model accumulates each
// driven sample; when a pass's last sample is driven, the expected centroid
// vector is pushed to a scoreboard queue and popped when out_valid pulses.
// Define KMEANS_ACCUM_COUNT_OUT_EN for both files to exercise the count outputs.
// -----------------------------------------------------------------------------
module tb_kmeans_accum_k3_d5;
  localparam int IW  = 16;
  localparam int CW  = 16;
  localparam int SW  = IW + CW;
  localparam int LAT = 15 * (SW + 2) + 1;

  typedef logic [14:0][IW-1:0] cvec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [IW-1:0] din [5];
  logic [1:0]    sel = 2'd0;
  logic          in_ready;
  logic          out_valid;
  logic [IW-1:0] cent [15];
`ifdef KMEANS_ACCUM_COUNT_OUT_EN
  logic [CW-1:0] cc [3];
  logic [CW-1:0] exp_cc [3];
`endif

  cvec_t         exp_q [$];
  longint        msum [3][5];
  longint        mcnt [3];
  logic [IW-1:0] mcent [15];
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  kmeans_accum_k3_d5 #(
    .input_data_width(IW),
    .count_width(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_last(in_last),
    .input_data0(din[0]),
    .input_data1(din[1]),
    .input_data2(din[2]),
    .input_data3(din[3]),
    .input_data4(din[4]),
    .selected_centroid(sel),
    .in_ready(in_ready),
    .centroid0_d0(cent[0]),
    .centroid0_d1(cent[1]),
    .centroid0_d2(cent[2]),
    .centroid0_d3(cent[3]),
    .centroid0_d4(cent[4]),
    .centroid1_d0(cent[5]),
    .centroid1_d1(cent[6]),
    .centroid1_d2(cent[7]),
    .centroid1_d3(cent[8]),
    .centroid1_d4(cent[9]),
    .centroid2_d0(cent[10]),
    .centroid2_d1(cent[11]),
    .centroid2_d2(cent[12]),
    .centroid2_d3(cent[13]),
    .centroid2_d4(cent[14]),
`ifdef KMEANS_ACCUM_COUNT_OUT_EN
    .cluster_count0(cc[0]),
    .cluster_count1(cc[1]),
    .cluster_count2(cc[2]),
`endif
    .out_valid(out_valid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = 0;
      for (int d = 0; d < 5; d++) msum[k][d] = 0;
    end
  endtask

  // Drive one sample for one cycle; the model mirrors the accumulation rules.
  task automatic send(input logic [IW-1:0] v0, input logic [IW-1:0] v1,
                      input logic [IW-1:0] v2, input logic [IW-1:0] v3,
                      input logic [IW-1:0] v4, input logic [1:0] s,
                      input logic last);
    cvec_t e;
    @(negedge clk);
    chk("in_ready_accum", in_ready, 1);
    din[0] = v0; din[1] = v1; din[2] = v2; din[3] = v3; din[4] = v4;
    sel = s;
    in_valid = 1'b1;
    in_last = last;
    $display("sample k=%0d data=(%0d,%0d,%0d,%0d,%0d) last=%0d", s, v0, v1, v2, v3, v4, last);
    if (s != 2'd3) begin
      msum[s][0] += v0; msum[s][1] += v1; msum[s][2] += v2;
      msum[s][3] += v3; msum[s][4] += v4;
      mcnt[s] += 1;
    end
    if (last) begin
      for (int k = 0; k < 3; k++) begin
        for (int d = 0; d < 5; d++) begin
          if (mcnt[k] != 0) mcent[k*5+d] = IW'(msum[k][d] / mcnt[k]);
          e[k*5+d] = mcent[k*5+d];
        end
      end
      exp_q.push_back(e);
`ifdef KMEANS_ACCUM_COUNT_OUT_EN
      for (int k = 0; k < 3; k++) exp_cc[k] = CW'(mcnt[k]);
`endif
      model_clear();
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
`ifdef KMEANS_ACCUM_COUNT_OUT_EN
    if (last) begin
      for (int k = 0; k < 3; k++) chk($sformatf("cluster_count%0d", k), cc[k], exp_cc[k]);
    end
`endif
  endtask

  // Called right after the in_last sample; counts cycles to the out_valid pulse.
  task automatic wait_done(input bit pulses);
    int cyc = 0;
    bit got = 0;
    bit ready_hi = 0;
    cvec_t e;
    while (!got && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (in_ready !== 1'b0) ready_hi = 1;
      if (out_valid === 1'b1) begin
        got = 1;
      end else if (pulses) begin
        // Junk samples that must be ignored while not ready.
        in_valid = (cyc % 7 == 3);
        in_last = 1'b1;
        sel = 2'd0;
        for (int d = 0; d < 5; d++) din[d] = 16'd999;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("latency", got ? 64'(cyc + 1) : 64'd0, LAT);
    chk("in_ready_low_div", ready_hi, 0);
    chk("scoreboard_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      $display("result latency=%0d c0=(%0d,%0d,%0d,%0d,%0d) c1=(%0d,%0d,%0d,%0d,%0d) c2=(%0d,%0d,%0d,%0d,%0d)",
               cyc + 1, cent[0], cent[1], cent[2], cent[3], cent[4], cent[5], cent[6],
               cent[7], cent[8], cent[9], cent[10], cent[11], cent[12], cent[13], cent[14]);
      for (int i = 0; i < 15; i++) chk($sformatf("centroid%0d_d%0d", i / 5, i % 5), cent[i], e[i]);
      @(posedge clk);
      #1;
      chk("out_valid_one_cycle", out_valid, 0);
      chk("in_ready_after_done", in_ready, 1);
      for (int i = 0; i < 15; i++) chk($sformatf("hold_c%0d_d%0d", i / 5, i % 5), cent[i], e[i]);
    end
  endtask

  initial begin
    bit ov_seen;
    for (int d = 0; d < 5; d++) din[d] = '0;
    for (int i = 0; i < 15; i++) mcent[i] = '0;
    model_clear();

    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    for (int i = 0; i < 15; i++) chk($sformatf("reset_c%0d_d%0d", i / 5, i % 5), cent[i], 0);
`ifdef KMEANS_ACCUM_COUNT_OUT_EN
    for (int k = 0; k < 3; k++) chk($sformatf("reset_count%0d", k), cc[k], 0);
`endif

    // Pass 1: two k0 samples, last sample accumulated before division
    send(10, 20, 30, 40, 50, 2'd0, 1'b0);
    send(30, 40, 50, 60, 70, 2'd0, 1'b1);
    wait_done(1'b0);
    chk("p1_c0_d0", cent[0], 20);
    chk("p1_c0_d4", cent[4], 60);
    chk("p1_c1_d0", cent[5], 0);
    chk("p1_c2_d4", cent[14], 0);

    // Pass 2: k1 only, truncating division; junk pulses during DIV
    send(1, 0, 0, 0, 0, 2'd1, 1'b0);
    repeat (2) @(posedge clk);
    send(2, 0, 0, 0, 0, 2'd1, 1'b0);
    send(2, 0, 0, 0, 0, 2'd1, 1'b1);
    wait_done(1'b1);
    chk("p2_c1_d0_trunc", cent[5], 1);
    chk("p2_c0_d2_kept", cent[2], 40);

    // Pass 3: lone selected_centroid=3 sample carrying in_last
    send(500, 500, 500, 500, 500, 2'd3, 1'b1);
    wait_done(1'b0);

    // Pass 4: 3 samples to k0, none to k1, 5 to k2
    for (int i = 0; i < 3; i++)
      send(IW'(i * 3 + 1), IW'(i * 100), 7, 16'hFFFF, 2, 2'd0, 1'b0);
    repeat (1) @(posedge clk);
    for (int j = 0; j < 5; j++)
      send(IW'(j + 1), IW'(j * 1000 + 5), 8, 13, IW'(65535 - j), 2'd2, j == 4);
    wait_done(1'b0);

    // Pass 5: reset 100 cycles into DIV, sample presented under reset
    send(16'hFFFF, 1, 2, 3, 4, 2'd1, 1'b0);
    send(16'hFFFF, 1, 2, 3, 4, 2'd1, 1'b1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    $display("reset asserted mid-division");
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    for (int i = 0; i < 15; i++) chk($sformatf("rst_c%0d_d%0d", i / 5, i % 5), cent[i], 0);
    @(negedge clk);
    in_valid = 1'b1; in_last = 1'b1; sel = 2'd0;
    for (int d = 0; d < 5; d++) din[d] = 16'd1000;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    void'(exp_q.pop_back());
    model_clear();
    for (int i = 0; i < 15; i++) mcent[i] = '0;
    ov_seen = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) ov_seen = 1;
    end
    chk("no_out_valid_after_abort", ov_seen, 0);

    // Pass 6: fresh pass after reset, including maximal-value sums
    send(16'hFFFF, 16'hFFFF, 1, 2, 3, 2'd1, 1'b0);
    send(16'hFFFF, 16'hFFFE, 2, 2, 2, 2'd1, 1'b0);
    send(7, 8, 9, 10, 11, 2'd2, 1'b1);
    wait_done(1'b0);
    chk("p6_c1_d0_max", cent[5], 65535);
    chk("p6_c1_d1", cent[6], 65534);
    chk("p6_c0_d0_zero", cent[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
